load_store_unit: RTL and testbench

Initiator side of the CPU data-memory interface. It accepts one load/store request at a time from the memory stage and drives a word-organised, byte-enabled, synchronous data memory. It generates byte enables and lane-shifted write data, and extracts and sign- or zero-extends load data. Misaligned accesses that cross a word boundary are split into two memory transactions by a state machine.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 80 ++++++++
 tb/tb_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response and data-memory bus bundle for the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  ReqValid;
  logic                  ReqReady;
  logic                  MemWrite;
  logic [2:0]            SizeCtr;
  logic [ADDR_WIDTH-1:0] ALUResult;
  logic [31:0]           WriteData;
  logic                  RespValid;
  logic                  RespErr;
  logic [31:0]           ReadData;
  logic                  MemEn;
  logic                  MemReady;
  logic                  MemWe;
  logic [ADDR_WIDTH-3:0] MemAddr;
  logic [3:0]            MemByteEn;
  logic [31:0]           MemWData;
  logic [31:0]           MemRData;
  modport master (
    input  ReqValid, MemWrite, SizeCtr, ALUResult, WriteData, MemReady, MemRData,
    output ReqReady, RespValid, RespErr, ReadData, MemEn, MemWe, MemAddr, MemByteEn, MemWData
  );
  modport slave (
    output ReqValid, MemWrite, SizeCtr, ALUResult, WriteData, MemReady, MemRData,
    input  ReqReady, RespValid, RespErr, ReadData, MemEn, MemWe, MemAddr, MemByteEn, MemWData
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte-enabled load/store initiator that splits word-crossing accesses
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE0 = 3'd1, WAIT0 = 3'd2, ISSUE1 = 3'd3, WAIT1 = 3'd4, RESP = 3'd5;
  logic [2:0]              r_state, w_next;
  logic                    r_we, r_err;
  logic [2:0]              r_size;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_lo, r_rdata;
  logic [1:0]              w_off;
  logic [3:0]              w_mask;
  logic [7:0]              w_be;
  logic [2*DATA_WIDTH-1:0] w_wd;
  logic                    w_split, w_legal, w_accept, w_issue, w_second;
  logic [DATA_WIDTH-1:0]   w_lo, w_hi, w_shr, w_ext;

  assign w_off    = r_addr[1:0];
  assign w_mask   = r_size[1] ? 4'hF : r_size[0] ? 4'h3 : 4'h1;
  assign w_split  = r_size[1] ? (w_off != 2'd0) : (r_size[0] && w_off == 2'd3);
  assign w_be     = {4'b0, w_mask} << w_off;
  assign w_wd     = {{DATA_WIDTH{1'b0}}, r_wdata} << {w_off, 3'b0};
  assign w_legal  = bus.MemWrite ? (bus.SizeCtr < 3'd3) : !(bus.SizeCtr == 3'd3 || bus.SizeCtr > 3'd5);
  assign w_accept = bus.ReqValid && r_state == IDLE;
  assign w_issue  = r_state == ISSUE0 || r_state == ISSUE1;
  assign w_second = r_state == ISSUE1;
  assign w_lo     = r_state == WAIT0 ? bus.MemRData : r_lo;
  assign w_hi     = r_state == WAIT1 ? bus.MemRData : '0;
  assign w_shr    = DATA_WIDTH'({w_hi, w_lo} >> {w_off, 3'b0});
  assign w_ext    = r_size[1] ? w_shr
                  : r_size[0] ? {{16{!r_size[2] && w_shr[15]}}, w_shr[15:0]}
                  : {{24{!r_size[2] && w_shr[7]}}, w_shr[7:0]};

  assign w_next = r_state == IDLE   ? (w_accept ? (w_legal ? ISSUE0 : RESP) : IDLE)
                : r_state == ISSUE0 ? (!bus.MemReady ? ISSUE0 : !r_we ? WAIT0 : w_split ? ISSUE1 : RESP)
                : r_state == WAIT0  ? (w_split ? ISSUE1 : RESP)
                : r_state == ISSUE1 ? (!bus.MemReady ? ISSUE1 : r_we ? RESP : WAIT1)
                : r_state == WAIT1  ? RESP
                : IDLE;

  assign bus.ReqReady  = r_state == IDLE;
  assign bus.RespValid = r_state == RESP;
  assign bus.RespErr   = r_state == RESP && r_err;
  assign bus.ReadData  = r_rdata;
  assign bus.MemEn     = w_issue;
  assign bus.MemWe     = w_issue && r_we;
  assign bus.MemAddr   = w_issue ? r_addr[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(w_second) : '0;
  assign bus.MemByteEn = w_issue ? (w_second ? w_be[7:4] : w_be[3:0]) : 4'b0;
  assign bus.MemWData  = w_issue ? (w_second ? w_wd[2*DATA_WIDTH-1:DATA_WIDTH] : w_wd[DATA_WIDTH-1:0]) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.MemWrite;
        r_size  <= bus.SizeCtr;
        r_addr  <= bus.ALUResult;
        r_wdata <= bus.WriteData;
        r_err   <= !w_legal;
      end
      if (w_accept && !w_legal) r_rdata <= '0;
      if (r_state == WAIT0) r_lo <= bus.MemRData;
      if ((r_state == WAIT0 && !w_split) || r_state == WAIT1) r_rdata <= w_ext;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed checks of the load/store unit against a byte-level memory model
module tb_load_store_unit;
  typedef struct {
    logic [14:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } txn_t;
  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(17)) bus ();
  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(17)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_chk = 0;
  int          n_pass = 0;
  txn_t        exp_q[$];
  txn_t        obs_q[$];
  rsp_t        resp_q[$];
  logic [31:0] mem_w [logic [14:0]];
  logic [7:0]  ref_b [logic [16:0]];
  bit          rdy_rand = 1'b0;
  int          stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: got an event or timeout, expected none", nm);
  endtask

  task automatic set_word(input logic [14:0] w, input logic [31:0] v);
    mem_w[w] = v;
    for (int i = 0; i < 4; i++) ref_b[{w, 2'(i)}] = v[8*i +: 8];
  endtask

  task automatic model(input logic we, input logic [2:0] sz, input logic [16:0] addr, input logic [31:0] wd);
    int          n;
    logic [16:0] b;
    logic [31:0] v;
    logic [63:0] wide;
    txn_t        t0, t1;
    rsp_t        r;
    bit          split;
    if (!(we ? sz inside {3'd0, 3'd1, 3'd2} : sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      r.err = 1'b1; r.chk_rd = 1'b1; r.rd = '0;
      resp_q.push_back(r);
      return;
    end
    n = sz[1:0] == 2'd0 ? 1 : sz[1:0] == 2'd1 ? 2 : 4;
    wide = {32'b0, wd} << (8 * addr[1:0]);
    t0.a = addr[16:2]; t0.be = '0; t0.wd = wide[31:0];  t0.we = we;
    t1.a = addr[16:2] + 15'd1; t1.be = '0; t1.wd = wide[63:32]; t1.we = we;
    split = 1'b0;
    v = '0;
    for (int k = 0; k < n; k++) begin
      b = addr + 17'(k);
      if (b[16:2] == t0.a) t0.be[b[1:0]] = 1'b1;
      else begin
        t1.be[b[1:0]] = 1'b1;
        split = 1'b1;
      end
      if (we) ref_b[b] = wd[8*k +: 8];
      else v = v | (32'(ref_b[b]) << (8 * k));
    end
    if (!we && sz == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (!we && sz == 3'd1) v = {{16{v[15]}}, v[15:0]};
    exp_q.push_back(t0);
    if (split) exp_q.push_back(t1);
    r.err = 1'b0; r.chk_rd = !we; r.rd = v;
    resp_q.push_back(r);
  endtask

  task automatic scramble();
    bus.MemWrite  = 1'($urandom);
    bus.SizeCtr   = 3'($urandom);
    bus.ALUResult = 17'($urandom);
    bus.WriteData = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [2:0] sz, input logic [16:0] addr,
                        input logic [31:0] wd, output int lat);
    int guard = 0;
    @(negedge clk);
    while (bus.ReqReady !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.ReqReady !== 1'b1) fail("req_ready_timeout");
    obs_q.delete();
    model(we, sz, addr, wd);
    bus.MemWrite = we; bus.SizeCtr = sz; bus.ALUResult = addr; bus.WriteData = wd;
    bus.ReqValid = 1'b1;
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    scramble();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.ReqValid = rdy_rand ? 1'($urandom) : 1'b0;
      scramble();
    end while (bus.RespValid !== 1'b1 && lat < 60);
    bus.ReqValid = 1'b0;
    if (bus.RespValid !== 1'b1) fail("resp_timeout");
  endtask

  task automatic chk_obs(input int i, input logic [14:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
    if (obs_q.size() <= i) begin
      fail("obs_missing");
      return;
    end
    chk("obs_addr", 32'(obs_q[i].a), 32'(a));
    chk("obs_be", 32'(obs_q[i].be), 32'(be));
    chk("obs_we", 32'(obs_q[i].we), 32'(we));
    if (we) chk("obs_wdata", obs_q[i].wd, wd);
  endtask

  initial begin
    logic        acc, we;
    logic [14:0] a;
    logic [3:0]  be;
    logic [31:0] wd, t;
    bus.MemReady = 1'b1;
    bus.MemRData = '0;
    forever begin
      @(negedge clk);
      acc = bus.MemEn === 1'b1 && bus.MemReady;
      we = bus.MemWe; a = bus.MemAddr; be = bus.MemByteEn; wd = bus.MemWData;
      if (bus.MemEn === 1'b1 && !bus.MemReady && stall > 0) stall--;
      @(posedge clk);
      #1;
      if (acc && we) begin
        t = mem_w.exists(a) ? mem_w[a] : '0;
        for (int i = 0; i < 4; i++) if (be[i]) t[8*i +: 8] = wd[8*i +: 8];
        mem_w[a] = t;
      end
      bus.MemRData = (acc && !we) ? (mem_w.exists(a) ? mem_w[a] : '0) : $urandom;
      bus.MemReady = stall > 0 ? 1'b0 : rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    txn_t e, o;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.MemEn === 1'b1) begin
          o.a = bus.MemAddr; o.be = bus.MemByteEn; o.wd = bus.MemWData; o.we = bus.MemWe;
          if (exp_q.size() == 0) fail("unexpected_txn");
          else begin
            e = exp_q[0];
            chk("mem_addr", 32'(o.a), 32'(e.a));
            chk("mem_be", 32'(o.be), 32'(e.be));
            chk("mem_we", 32'(o.we), 32'(e.we));
            if (e.we) chk("mem_wdata", o.wd, e.wd);
            if (bus.MemReady) void'(exp_q.pop_front());
          end
          if (bus.MemReady) obs_q.push_back(o);
        end
        if (bus.RespValid === 1'b1) begin
          if (resp_q.size() == 0) fail("unexpected_resp");
          else begin
            r = resp_q.pop_front();
            chk("resp_err", 32'(bus.RespErr), 32'(r.err));
            if (r.chk_rd) chk("read_data", bus.ReadData, r.rd);
          end
        end
      end
    end
  end

  initial begin
    int          lat;
    logic        we;
    logic [2:0]  sz;
    logic [14:0] w;
    bus.ReqValid = 1'b0;
    bus.MemWrite = 1'b0; bus.SizeCtr = '0; bus.ALUResult = '0; bus.WriteData = '0;
    for (int i = 0; i < 9; i++) set_word(15'(i), $urandom);
    for (int i = 0; i < 8; i++) set_word(15'(32'h7FF8 + i), $urandom);
    set_word(15'h040, 32'hDEADBEEF);
    set_word(15'h400, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.ReqReady), 32'd1);
    chk("rst_resp_valid", 32'(bus.RespValid), 32'd0);
    chk("rst_resp_err", 32'(bus.RespErr), 32'd0);
    chk("rst_mem_en", 32'(bus.MemEn), 32'd0);
    chk("rst_mem_we", 32'(bus.MemWe), 32'd0);
    chk("rst_mem_be", 32'(bus.MemByteEn), 32'd0);
    chk("rst_read_data", bus.ReadData, 32'd0);
    chk("rst_mem_addr", 32'(bus.MemAddr), 32'd0);
    chk("rst_mem_wdata", bus.MemWData, 32'd0);

    do_req(1'b0, 3'b010, 17'h0100, 32'h0, lat);
    chk("lw_latency", 32'(lat), 32'd3);
    chk("lw_data", bus.ReadData, 32'hDEADBEEF);
    chk_obs(0, 15'h040, 4'b1111, 32'h0, 1'b0);
    @(negedge clk);
    chk("lw_ready_again", 32'(bus.ReqReady), 32'd1);

    set_word(15'h040, 32'h80000000);
    do_req(1'b0, 3'b000, 17'h0103, 32'h0, lat);
    chk("lb_data", bus.ReadData, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 17'h0103, 32'h0, lat);
    chk("lbu_data", bus.ReadData, 32'h00000080);
    do_req(1'b0, 3'b001, 17'h0102, 32'h0, lat);
    chk("lh_data", bus.ReadData, 32'hFFFF8000);

    do_req(1'b1, 3'b001, 17'h1002, 32'h0000ABCD, lat);
    chk("sh_latency", 32'(lat), 32'd2);
    chk("sh_txn_count", 32'(obs_q.size()), 32'd1);
    chk_obs(0, 15'h400, 4'b1100, 32'hABCD0000, 1'b1);

    do_req(1'b1, 3'b010, 17'h0005, 32'h11223344, lat);
    chk("sw_split_latency", 32'(lat), 32'd3);
    chk("sw_split_txn_count", 32'(obs_q.size()), 32'd2);
    chk_obs(0, 15'h001, 4'b1110, 32'h22334400, 1'b1);
    chk_obs(1, 15'h002, 4'b0001, 32'h00000011, 1'b1);

    set_word(15'h001, 32'hAABBCCDD);
    set_word(15'h002, 32'h11223344);
    do_req(1'b0, 3'b010, 17'h0006, 32'h0, lat);
    chk("lw_split_latency", 32'(lat), 32'd5);
    chk("lw_split_data", bus.ReadData, 32'h3344AABB);
    @(negedge clk);
    stall = 3;
    do_req(1'b0, 3'b010, 17'h0006, 32'h0, lat);
    chk("lw_stall_latency", 32'(lat), 32'd8);
    chk("lw_stall_data", bus.ReadData, 32'h3344AABB);

    obs_q.delete();
    model(1'b0, 3'b010, 17'h0006, 32'h0);
    @(negedge clk);
    bus.MemWrite = 1'b0; bus.SizeCtr = 3'b010; bus.ALUResult = 17'h0006; bus.ReqValid = 1'b1;
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    resp_q.delete();
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.ReqReady), 32'd1);
    chk("mid_rst_mem_en", 32'(bus.MemEn), 32'd0);
    chk("mid_rst_resp", 32'(bus.RespValid), 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_txn_count", 32'(obs_q.size()), 32'd1);

    do_req(1'b0, 3'b011, 17'h0010, 32'h0, lat);
    chk("ld_err_latency", 32'(lat), 32'd1);
    chk("ld_err_flag", 32'(bus.RespErr), 32'd1);
    chk("ld_err_data", bus.ReadData, 32'd0);
    chk("ld_err_no_txn", 32'(obs_q.size()), 32'd0);
    do_req(1'b1, 3'b100, 17'h0010, 32'h12345678, lat);
    chk("st_err_latency", 32'(lat), 32'd1);
    chk("st_err_flag", 32'(bus.RespErr), 32'd1);
    chk("st_err_data", bus.ReadData, 32'd0);
    chk("st_err_no_txn", 32'(obs_q.size()), 32'd0);

    rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom);
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 4) > 2) ? $urandom_range(4, 5) : $urandom_range(0, 2));
      w = $urandom_range(0, 1) ? 15'($urandom_range(0, 7)) : 15'($urandom_range(32'h7FF8, 32'h7FFF));
      do_req(we, sz, {w, 2'($urandom)}, $urandom, lat);
    end
    rdy_rand = 1'b0;
    repeat (5) @(negedge clk);
    chk("txn_left", 32'(exp_q.size()), 32'd0);
    chk("resp_left", 32'(resp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
